// File: rtl/mod_n_updn_counter_p.sv
// Modulo-N up/down/ping-pong counter with parallel load, optional saturation,
// a registered terminal-count pulse and a registered direction flag.
module mod_n_updn_counter_p #(
    parameter int WIDTH    = 4,
    parameter int MOD      = 10,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             dir
);

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_PING = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    // One extra bit so that MOD = 2**WIDTH and the +1 step never overflow.
    localparam logic [WIDTH:0] LAST = (WIDTH+1)'(MOD - 1);
    localparam logic [WIDTH:0] ONE  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] ZERO = '0;

    logic [WIDTH-1:0] out_q, out_d;
    logic             tc_q, tc_d;
    logic             dir_q, dir_d;

    logic [WIDTH:0]   cnt_w;
    logic [WIDTH:0]   load_w;
    logic [WIDTH:0]   nxt_w;
    mode_e            mode_w;

    // Next-state: load beats enable; every non-limit step clears tc.
    always_comb begin
        cnt_w  = {1'b0, out_q};
        load_w = {1'b0, load_val};
        mode_w = mode_e'(mode);
        nxt_w  = cnt_w;
        tc_d   = 1'b0;
        dir_d  = dir_q;
        if (load) begin
            nxt_w = (load_w > LAST) ? LAST : load_w;
        end else if (en && (mode_w != MODE_HOLD)) begin
            if (cnt_w > LAST) begin
                // Only reachable with an illegal MOD; snap back into range.
                nxt_w = ZERO;
                tc_d  = 1'b1;
            end else begin
                case (mode_w)
                    MODE_UP: begin
                        dir_d = 1'b1;
                        if (cnt_w == LAST) begin
                            tc_d  = 1'b1;
                            nxt_w = SATURATE ? LAST : ZERO;
                        end else begin
                            nxt_w = cnt_w + ONE;
                        end
                    end
                    MODE_DOWN: begin
                        dir_d = 1'b0;
                        if (cnt_w == ZERO) begin
                            tc_d  = 1'b1;
                            nxt_w = SATURATE ? ZERO : LAST;
                        end else begin
                            nxt_w = cnt_w - ONE;
                        end
                    end
                    MODE_PING: begin
                        // Ping-pong bounces off the limits, never wraps or sticks.
                        if (dir_q) begin
                            if (cnt_w == LAST) begin
                                nxt_w = LAST - ONE;
                                dir_d = 1'b0;
                                tc_d  = 1'b1;
                            end else begin
                                nxt_w = cnt_w + ONE;
                            end
                        end else begin
                            if (cnt_w == ZERO) begin
                                nxt_w = ONE;
                                dir_d = 1'b1;
                                tc_d  = 1'b1;
                            end else begin
                                nxt_w = cnt_w - ONE;
                            end
                        end
                    end
                    default: begin
                        nxt_w = cnt_w;
                    end
                endcase
            end
        end
        out_d = WIDTH'(nxt_w);
    end

    // State registers; reset forces count 0, no pulse, counting up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= '0;
            tc_q  <= 1'b0;
            dir_q <= 1'b1;
        end else begin
            out_q <= out_d;
            tc_q  <= tc_d;
            dir_q <= dir_d;
        end
    end

    assign out = out_q;
    assign tc  = tc_q;
    assign dir = dir_q;

endmodule

// File: tb/tb_mod_n_updn_counter_p.sv
// Directed bench: four counter instances (wrap, saturate, MOD=2, MOD=16)
// share one stimulus stream; each is checked against hand-derived values.
module tb_mod_n_updn_counter_p;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic       load;
    logic [3:0] load_val;

    logic [3:0] a_out, s_out, p_out, m_out;
    logic       a_tc, s_tc, p_tc, m_tc;
    logic       a_dir, s_dir, p_dir, m_dir;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mod_n_updn_counter_p #(.WIDTH(4), .MOD(10), .SATURATE(1'b0)) u_a (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load),
        .load_val(load_val), .out(a_out), .tc(a_tc), .dir(a_dir));

    mod_n_updn_counter_p #(.WIDTH(4), .MOD(10), .SATURATE(1'b1)) u_s (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load),
        .load_val(load_val), .out(s_out), .tc(s_tc), .dir(s_dir));

    mod_n_updn_counter_p #(.WIDTH(4), .MOD(2), .SATURATE(1'b0)) u_p (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load),
        .load_val(load_val), .out(p_out), .tc(p_tc), .dir(p_dir));

    mod_n_updn_counter_p #(.WIDTH(4), .MOD(16), .SATURATE(1'b0)) u_m (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load),
        .load_val(load_val), .out(m_out), .tc(m_tc), .dir(m_dir));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset across one edge, release 1 time unit after the next edge.
    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int exp_o;
        int pp_out [13] = '{8, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
        int pp_tc  [13] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        int pp_dir [13] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};

        reset = 1'b1; en = 1'b0; mode = 2'b11; load = 1'b0; load_val = '0;
        #3;
        chk("rst_out", 32'(a_out), 0);
        chk("rst_tc",  32'(a_tc),  0);
        chk("rst_dir", 32'(a_dir), 1);
        tick();
        reset = 1'b0;

        // Mode 00 from 0: wrap vs saturate.
        en = 1'b1; mode = 2'b00;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("up_out[%0d]", i), 32'(a_out), 32'((i + 1) % 10));
            chk($sformatf("up_tc[%0d]", i),  32'(a_tc),  (i == 9) ? 1 : 0);
            chk($sformatf("up_dir[%0d]", i), 32'(a_dir), 1);
            exp_o = (i + 1 > 9) ? 9 : i + 1;
            chk($sformatf("sat_out[%0d]", i), 32'(s_out), 32'(exp_o));
            chk($sformatf("sat_tc[%0d]", i),  32'(s_tc),  (i >= 9) ? 1 : 0);
        end

        // Asynchronous reset in the middle of counting at 7.
        do_reset();
        for (int i = 0; i < 7; i++) tick();
        chk("pre_arst_out", 32'(a_out), 7);
        #3 reset = 1'b1;
        #1;
        chk("arst_out", 32'(a_out), 0);
        chk("arst_tc",  32'(a_tc),  0);
        chk("arst_dir", 32'(a_dir), 1);
        load = 1'b1; load_val = 4'd5;
        tick();
        chk("arst_hold_out", 32'(a_out), 0);
        load = 1'b0;
        #2 reset = 1'b0;
        tick();
        chk("arst_first_out", 32'(a_out), 1);

        // Mode 01 from 0, then enable low.
        do_reset();
        mode = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("dn_out[%0d]", i), 32'(a_out), 32'(9 - i));
            chk($sformatf("dn_tc[%0d]", i),  32'(a_tc),  (i == 0) ? 1 : 0);
            chk($sformatf("dn_dir[%0d]", i), 32'(a_dir), 0);
            chk($sformatf("sdn_out[%0d]", i), 32'(s_out), 0);
            chk($sformatf("sdn_tc[%0d]", i),  32'(s_tc),  1);
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("frz_out[%0d]", i), 32'(a_out), 7);
            chk($sformatf("frz_tc[%0d]", i),  32'(a_tc),  0);
            chk($sformatf("sfrz_tc[%0d]", i), 32'(s_tc),  0);
        end

        // Ping-pong from 7 going up; MOD=2 instance sits at 1 going up.
        do_reset();
        en = 1'b1; mode = 2'b00;
        for (int i = 0; i < 7; i++) tick();
        chk("pp_start", 32'(a_out), 7);
        chk("pp2_start", 32'(p_out), 1);
        mode = 2'b10;
        for (int i = 0; i < 13; i++) begin
            tick();
            chk($sformatf("pp_out[%0d]", i), 32'(a_out), 32'(pp_out[i]));
            chk($sformatf("pp_tc[%0d]", i),  32'(a_tc),  32'(pp_tc[i]));
            chk($sformatf("pp_dir[%0d]", i), 32'(a_dir), 32'(pp_dir[i]));
            chk($sformatf("spp_out[%0d]", i), 32'(s_out), 32'(pp_out[i]));
            chk($sformatf("pp2_out[%0d]", i), 32'(p_out), (i % 2 == 0) ? 0 : 1);
            chk($sformatf("pp2_tc[%0d]", i),  32'(p_tc),  1);
        end

        // Load: clamp, priority over enable/mode, dir untouched.
        load = 1'b1; load_val = 4'd13; mode = 2'b01;
        tick();
        chk("ld13_out", 32'(a_out), 9);
        chk("ld13_tc",  32'(a_tc),  0);
        chk("ld13_dir", 32'(a_dir), 1);
        chk("ld13_m16", 32'(m_out), 13);
        load_val = 4'd4; mode = 2'b11;
        tick();
        chk("ld4_out", 32'(a_out), 4);
        load = 1'b0;
        tick();
        chk("hold_out", 32'(a_out), 4);
        chk("hold_tc",  32'(a_tc),  0);

        // Full-range modulus: 15 wraps to 0.
        do_reset();
        mode = 2'b00;
        for (int i = 0; i < 17; i++) begin
            tick();
            chk($sformatf("m16_out[%0d]", i), 32'(m_out), 32'((i + 1) % 16));
            chk($sformatf("m16_tc[%0d]", i),  32'(m_tc),  (i == 15) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
